sort_sequencer: RTL and testbench
=================================

# sort_sequencer

Iterative 8-entry, 8-bit sorter controller. It loads eight bytes serially, repeatedly applies one internal single-pass bubble network (the same compare-swap chain that floats the largest value to the top slot) to a register bank until the bank is sorted, then streams the sorted bytes out smallest-first. It sits between a byte-stream producer and consumer and time-shares one pass network over up to seven cycles, instead of instantiating a full seven-stage combinational sorter.

## Interface
Parameters:
- W, 8: element width in bits; comparison is unsigned.
- EARLY_EXIT, 1: when 1, sorting ends after the first pass that performs no swap; when 0, exactly 7 passes always run.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts input this cycle (high only in LOAD).
- in_data  input  W  element to load.
- out_valid  output  1  out_data is valid (high only in DRAIN).
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  W  sorted element, smallest first.
- out_last  output  1  high with the 8th (largest) output element.
- busy  output  1  high in SORT or DRAIN.
- passes  output  3  number of SORT cycles used by the most recent block; holds until the next block enters SORT.

## Operation
- Storage: bank r[0..7] of W bits, load/drain index idx[2:0], pass counter pc[2:0].
- Pass network: combinational function of r. Compare-swap chain (0,1), (carry,2), …, (carry,7); each step outputs the smaller value to slot k and carries the larger. Carry out is written to slot 7. Swap only when strictly greater, so equal values never move. swap_seen = pass output ≠ r.
- FSM states:
  - LOAD: in_ready=1. On in_valid, r[idx] ← in_data and idx++. When the element accepted is at idx=7, go to SORT with idx=0 and pc=0.
  - SORT: each cycle, r ← pass(r) and pc++. Leave for DRAIN when pc+1 = 7, or when EARLY_EXIT=1 and !swap_seen. On leaving, passes ← pc+1.
  - DRAIN: out_valid=1, out_data=r[idx], out_last=(idx==7). On out_ready, idx++. When the element accepted is at idx=7, go to LOAD with idx=0.
- in_ready and out_valid are never high together. Input presented during SORT or DRAIN is ignored (not accepted).
- Reset, including mid-SORT or mid-DRAIN, has the same effect:
  - State goes to LOAD; idx, pc and passes go to 0; r clears to 0.
  - The partial block is discarded.
- Reset values of outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, passes=0.

## Timing
- Input throughput is 1 element/cycle. Output throughput is 1 element/cycle with out_ready held high.
- Let P be the number of passes, 1..7. out_valid rises P cycles after the edge that accepts the 8th input. P=7 is worst case; P=1 for already-sorted data when EARLY_EXIT=1.
- in_ready rises in the cycle after the edge that accepts the out_last element.
- Minimum block period is 8 + P + 8 cycles.
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- pass output is combinational from r only. No input port feeds an output combinationally: in_ready, out_valid, out_data, out_last and busy derive from registers.

## Test plan
- Reverse-sorted load 80,70,60,50,40,30,20,10, out_ready=1 → out 10,20,30,40,50,60,70,80; out_last only on 80; passes=7; out_valid rises 7 cycles after the 8th accept.
- Already-sorted load 1..8:
  - EARLY_EXIT=1 → passes=1, out_valid 1 cycle after the 8th accept.
  - EARLY_EXIT=0 → passes=7.
  - Output in both cases is 1..8.
- Duplicates and extremes: load 255,0,7,7,255,0,128,7 → out 0,0,7,7,7,128,255,255.
- Handshake stress:
  - Random in_valid gaps while loading 3,1,2,8,6,5,7,4.
  - out_ready toggling 1,0,0,1 repeating.
  - Required: out 1..8 in order, no element dropped or duplicated, out_data constant during stalls, in_valid during SORT/DRAIN not accepted.
- Reset mid-operation:
  - Assert rst on the 3rd SORT cycle → next cycle in_ready=1, busy=0, passes=0, out_valid=0.
  - A fresh load of 9,8,…,2 then sorts to 2..9 with passes=7.
- Back-to-back blocks: two blocks driven with no idle cycles → second block's first element accepted the cycle after the first block's out_last transfer; both outputs correct.

Source files
------------

// File: rtl/sort_sequencer.sv
// sort_sequencer: loads eight W-bit elements, sorts them in place by
// repeatedly applying one bubble pass (largest value floats to slot 7),
// then streams the bank out smallest-first.
module sort_sequencer #(
   parameter int W          = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy,
   output logic [2:0]   passes
);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SORT  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [2:0]   idx_q, idx_d;
   logic [2:0]   pc_q, pc_d;
   logic [2:0]   passes_q, passes_d;
   logic [W-1:0] r_q [8];
   logic [W-1:0] r_d [8];

   logic [W-1:0] pass_out [8];
   logic [W-1:0] carry;
   logic [7:0]   slot_changed;
   logic         swap_seen;

   // One bubble pass: compare-swap chain that carries the running maximum
   // upward. A swap only happens on strictly-greater so equal keys stay put.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         pass_out[k] = '0;
      end
      carry = r_q[0];
      for (int k = 1; k < 8; k++) begin
         if (carry > r_q[k]) begin
            pass_out[k-1] = r_q[k];
         end else begin
            pass_out[k-1] = carry;
            carry         = r_q[k];
         end
      end
      pass_out[7] = carry;
   end

   // Per-slot change flags; any change means this pass moved something.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_diff
         assign slot_changed[gi] = (pass_out[gi] != r_q[gi]);
      end
   endgenerate

   assign swap_seen = |slot_changed;

   // Next-state logic for the LOAD / SORT / DRAIN controller and the bank.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pc_d     = pc_q;
      passes_d = passes_q;
      for (int k = 0; k < 8; k++) begin
         r_d[k] = r_q[k];
      end

      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               r_d[idx_q] = in_data;
               idx_d      = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = ST_SORT;
                  idx_d   = 3'd0;
                  pc_d    = 3'd0;
               end
            end
         end
         ST_SORT: begin
            for (int k = 0; k < 8; k++) begin
               r_d[k] = pass_out[k];
            end
            pc_d = pc_q + 3'd1;
            // Seven passes always suffice for eight elements; a pass with no
            // movement proves the bank is already ordered.
            if ((pc_q == 3'd6) || (EARLY_EXIT && !swap_seen)) begin
               state_d  = ST_DRAIN;
               passes_d = pc_q + 3'd1;
               idx_d    = 3'd0;
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = ST_LOAD;
                  idx_d   = 3'd0;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
            idx_d   = 3'd0;
         end
      endcase
   end

   // State registers; reset discards any partial block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         idx_q    <= 3'd0;
         pc_q     <= 3'd0;
         passes_q <= 3'd0;
         for (int k = 0; k < 8; k++) begin
            r_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         pc_q     <= pc_d;
         passes_q <= passes_d;
         for (int k = 0; k < 8; k++) begin
            r_q[k] <= r_d[k];
         end
      end
   end

   // All outputs come from registers only.
   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_DRAIN);
   assign out_data  = r_q[idx_q];
   assign out_last  = (state_q == ST_DRAIN) && (idx_q == 3'd7);
   assign busy      = (state_q == ST_SORT) || (state_q == ST_DRAIN);
   assign passes    = passes_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed testbench for sort_sequencer (EARLY_EXIT=1 main instance plus an
// EARLY_EXIT=0 instance sharing the same inputs).
module tb_sort_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       in_ready, out_valid, out_last, busy;
   logic [7:0] out_data;
   logic [2:0] passes;

   logic       in_ready0, out_valid0, out_last0, busy0;
   logic [7:0] out_data0;
   logic [2:0] passes0;

   int checks = 0;
   int errors = 0;

   logic [7:0] load_vals [8];
   logic [7:0] exp_vals [8];
   int         gaps [8];
   bit         junk = 1'b0;

   always #5 clk = ~clk;

   sort_sequencer #(.W(8), .EARLY_EXIT(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .passes(passes)
   );

   sort_sequencer #(.W(8), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_last(out_last0), .busy(busy0), .passes(passes0)
   );

   task automatic apply_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clear_gaps();
      for (int i = 0; i < 8; i++) gaps[i] = 0;
   endtask

   // Presents load_vals with gaps[i] idle cycles before element i.
   task automatic do_load();
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < gaps[i]; g++) begin
            in_valid = 1'b0;
            @(posedge clk); @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = load_vals[i];
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready elem %0d: got %b want 1", i, in_ready);
         end
         @(posedge clk); @(negedge clk);
      end
      in_valid = junk;
      in_data  = 8'd99;
   endtask

   // Counts cycles from the 8th accept until out_valid rises.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         if (junk) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_in_sort cyc %0d: got %b want 0", cyc, in_ready);
            end
         end
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL valid_timeout: out_valid=%b after %0d cycles want 1", out_valid, cyc);
      end
   endtask

   // Drains eight elements; pattern 0 = out_ready high, 1 = 1,0,0,1 repeating.
   task automatic do_drain(input int pattern);
      int n = 0;
      int cyc = 0;
      logic [7:0] prev = 8'd0;
      bit stalled = 1'b0;
      while (n < 8 && cyc < 60) begin
         out_ready = (pattern == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (stalled) begin
            checks++;
            if (out_data !== prev) begin
               errors++;
               $display("FAIL stall_stable: got %0d want %0d", out_data, prev);
            end
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_in_drain: got %b want 0", in_ready);
            end
            if (out_ready) begin
               checks++;
               if (out_data !== exp_vals[n]) begin
                  errors++;
                  $display("FAIL out_data[%0d]: got %0d want %0d", n, out_data, exp_vals[n]);
               end
               checks++;
               if (out_last !== (n == 7)) begin
                  errors++;
                  $display("FAIL out_last[%0d]: got %b want %b", n, out_last, (n == 7));
               end
               $display("  out[%0d] = %0d last=%b", n, out_data, out_last);
               n++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               prev    = out_data;
            end
         end
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL drain_count: got %0d elements want 8", n);
      end
      in_valid = 1'b0;
      junk     = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_last: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
          out_data !== 8'd0 || busy !== 1'b0 || passes !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs: ir=%b ov=%b ol=%b od=%0d busy=%b passes=%0d want 1 0 0 0 0 0",
                  in_ready, out_valid, out_last, out_data, busy, passes);
      end
      $display("reset: ir=%b ov=%b busy=%b passes=%0d", in_ready, out_valid, busy, passes);
   endtask

   task automatic test_reverse();
      int cyc;
      apply_reset();
      clear_gaps();
      for (int i = 0; i < 8; i++) begin
         load_vals[i] = 8'(80 - 10 * i);
         exp_vals[i]  = 8'(10 + 10 * i);
      end
      do_load();
      wait_valid(cyc);
      checks++;
      if (cyc != 7) begin
         errors++;
         $display("FAIL reverse_latency: got %0d want 7", cyc);
      end
      checks++;
      if (passes !== 3'd7) begin
         errors++;
         $display("FAIL reverse_passes: got %0d want 7", passes);
      end
      $display("reverse: latency=%0d passes=%0d", cyc, passes);
      do_drain(0);
   endtask

   task automatic test_sorted();
      int first1 = -1, first0 = -1, n1 = 0, n0 = 0;
      logic [7:0] got1 [8];
      logic [7:0] got0 [8];
      bit last0_ok = 1'b1;
      apply_reset();
      clear_gaps();
      for (int i = 0; i < 8; i++) begin
         load_vals[i] = 8'(i + 1);
         got1[i] = 8'd0;
         got0[i] = 8'd0;
      end
      out_ready = 1'b1;
      do_load();
      for (int c = 0; c < 40; c++) begin
         if (out_valid === 1'b1) begin
            if (first1 < 0) first1 = c;
            if (n1 < 8) got1[n1] = out_data;
            n1++;
         end
         if (out_valid0 === 1'b1) begin
            if (first0 < 0) first0 = c;
            if (n0 < 8) got0[n0] = out_data0;
            if (out_last0 !== (n0 == 7)) last0_ok = 1'b0;
            n0++;
         end
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (first1 != 1 || passes !== 3'd1) begin
         errors++;
         $display("FAIL sorted_early: latency=%0d passes=%0d want 1/1", first1, passes);
      end
      checks++;
      if (first0 != 7 || passes0 !== 3'd7) begin
         errors++;
         $display("FAIL sorted_noearly: latency=%0d passes=%0d want 7/7", first0, passes0);
      end
      checks++;
      if (n1 != 8 || n0 != 8 || !last0_ok) begin
         errors++;
         $display("FAIL sorted_count: n1=%0d n0=%0d last0_ok=%b want 8 8 1", n1, n0, last0_ok);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got1[i] !== 8'(i + 1) || got0[i] !== 8'(i + 1)) begin
            errors++;
            $display("FAIL sorted_data[%0d]: got %0d/%0d want %0d", i, got1[i], got0[i], i + 1);
         end
      end
      checks++;
      if (busy0 !== 1'b0 || in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL sorted_idle0: busy0=%b in_ready0=%b want 0/1", busy0, in_ready0);
      end
      $display("sorted: lat1=%0d passes1=%0d lat0=%0d passes0=%0d", first1, passes, first0, passes0);
   endtask

   task automatic test_dups();
      int cyc;
      logic [7:0] v [8] = '{8'd255, 8'd0, 8'd7, 8'd7, 8'd255, 8'd0, 8'd128, 8'd7};
      logic [7:0] e [8] = '{8'd0, 8'd0, 8'd7, 8'd7, 8'd7, 8'd128, 8'd255, 8'd255};
      apply_reset();
      clear_gaps();
      for (int i = 0; i < 8; i++) begin
         load_vals[i] = v[i];
         exp_vals[i]  = e[i];
      end
      do_load();
      wait_valid(cyc);
      $display("dups: latency=%0d passes=%0d", cyc, passes);
      do_drain(0);
   endtask

   task automatic test_handshake();
      int cyc;
      logic [7:0] v [8] = '{8'd3, 8'd1, 8'd2, 8'd8, 8'd6, 8'd5, 8'd7, 8'd4};
      int g [8] = '{0, 1, 2, 0, 1, 0, 3, 1};
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         load_vals[i] = v[i];
         exp_vals[i]  = 8'(i + 1);
         gaps[i]      = g[i];
      end
      junk = 1'b1;
      do_load();
      wait_valid(cyc);
      $display("handshake: latency=%0d passes=%0d", cyc, passes);
      do_drain(1);
   endtask

   task automatic test_reset_mid();
      int cyc;
      clear_gaps();
      for (int i = 0; i < 8; i++) load_vals[i] = 8'(80 - 10 * i);
      do_load();
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: got %b want 1", busy);
      end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || passes !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: ir=%b busy=%b passes=%0d ov=%b want 1 0 0 0",
                  in_ready, busy, passes, out_valid);
      end
      for (int i = 0; i < 8; i++) begin
         load_vals[i] = 8'(9 - i);
         exp_vals[i]  = 8'(2 + i);
      end
      do_load();
      wait_valid(cyc);
      checks++;
      if (cyc != 7 || passes !== 3'd7) begin
         errors++;
         $display("FAIL mid_reload: latency=%0d passes=%0d want 7/7", cyc, passes);
      end
      $display("reset_mid: reload latency=%0d passes=%0d", cyc, passes);
      do_drain(0);
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [7:0] va [8] = '{8'd3, 8'd1, 8'd2, 8'd8, 8'd6, 8'd5, 8'd7, 8'd4};
      logic [7:0] vb [8] = '{8'd200, 8'd100, 8'd150, 8'd50, 8'd250, 8'd0, 8'd25, 8'd75};
      logic [7:0] eb [8] = '{8'd0, 8'd25, 8'd50, 8'd75, 8'd100, 8'd150, 8'd200, 8'd250};
      apply_reset();
      clear_gaps();
      for (int i = 0; i < 8; i++) begin
         load_vals[i] = va[i];
         exp_vals[i]  = 8'(i + 1);
      end
      do_load();
      wait_valid(cyc);
      do_drain(0);
      for (int i = 0; i < 8; i++) begin
         load_vals[i] = vb[i];
         exp_vals[i]  = eb[i];
      end
      do_load();
      wait_valid(cyc);
      $display("back_to_back: block B latency=%0d passes=%0d", cyc, passes);
      do_drain(0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
      test_reset();
      test_reverse();
      test_sorted();
      test_dups();
      test_handshake();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
